pm_boot_loader: RTL and testbench
=================================

// Module: pm_boot_loader
// PURPOSE
//  Boot-time program-memory loader that sits upstream of the core. Accepts a byte
//  stream (header, instruction words, checksum), assembles PMD_SIZE-bit words and
//  writes them into program memory through the PM write port.
//  Holds the core in reset until the image is loaded and verified, then releases it.
// PARAMETERS
//  PMA_SIZE  16  program memory address width
//  PMD_SIZE  32  program memory data width; must be a multiple of 8
//  BASE_ADD  0   PM address of the first loaded word
// PORTS
//  clk           in   1         core clock
//  reset         in   1         synchronous, active-high reset
//  ldr_in_vld    in   1         input byte valid
//  ldr_in_dt     in   8         input byte
//  ldr_in_rdy    out  1         loader can accept a byte this cycle
//  ldr_pm_cslt   out  1         PM chip select (write strobe)
//  ldr_pm_wrb    out  1         PM write enable (1 = write)
//  ldr_pm_add    out  PMA_SIZE  PM write address
//  ldr_pm_dt     out  PMD_SIZE  PM write data
//  ldr_core_rst  out  1         reset to core; 1 until load is verified
//  ldr_done      out  1         load completed, checksum good (sticky)
//  ldr_err       out  1         load failed (sticky until reset)
// BEHAVIOUR
//  - A byte transfers on a rising clk edge when ldr_in_vld & ldr_in_rdy. No other byte is consumed.
//  - Reset values: ldr_in_rdy=0, cslt=0, wrb=0, add=0, dt=0, core_rst=1, done=0, err=0.
//    State goes to HDR0. Word, byte, and address counters and the checksum clear.
//    rdy rises the cycle after reset deasserts.
//  - Stream format:
//    * 2-byte word count N, MSB first.
//    * N words of PMD_SIZE/8 bytes each, MSB first.
//    * 1 checksum byte equal to the XOR of all data bytes. Header bytes are excluded.
//  - FSM states: HDR0 -> HDR1 -> (DATA <-> WR)* -> CHK -> DONE | ERR.
//  - HDR0 and HDR1 latch N[15:8] and N[7:0].
//    * From HDR1: if BASE_ADD+N > 2**PMA_SIZE, go to ERR. Else if N==0, go to CHK. Else go to DATA.
//  - DATA shifts bytes into the word register and XORs each byte into the checksum.
//    * When the last byte of a word is accepted, go to WR.
//  - WR is exactly one cycle:
//    * cslt=1, wrb=1, add=BASE_ADD+word index, dt=assembled word. rdy=0.
//    * Then the word index increments. If index==N, go to CHK. Else go to DATA.
//    * Latency from the last byte accepted to the write strobe is 1 cycle.
//  - Outside WR: cslt=0 and wrb=0. add and dt hold their last values.
//  - CHK accepts one byte.
//    * Equal to the running XOR: go to DONE.
//    * Not equal: go to ERR.
//  - DONE: done=1 and core_rst=0 from the cycle after the checksum byte. rdy=0. Holds until reset.
//  - ERR: err=1 and core_rst=1. rdy=0. Holds until reset.
//    * Words already written are not undone.
//  - rdy=1 only in HDR0, HDR1, DATA and CHK. Bytes offered while rdy=0 are ignored and not buffered.
//  - Gaps in vld at any point, including mid-word, have no effect other than stalling.
//  - Reset mid-load, including mid-word or during WR, aborts with no further PM write.
//    Any partial word is discarded. The next header starts a fresh load.
//  - Address arithmetic uses PMA_SIZE+1 bits for the overflow check. The word index never wraps.
// TESTING
//  1. PMD=32, BASE=0. Bytes 00 02 11 22 33 44 55 66 77 88 88.
//     -> writes 0x11223344@0 and 0x55667788@1. done=1, core_rst=0 one cycle after the last byte.
//  2. Same stream with checksum 89.
//     -> both writes occur. err=1, core_rst stays 1, done=0.
//  3. Bytes 00 00 00.
//     -> no PM write. done=1 after the third byte.
//  4. Case 1 with vld low on alternate cycles and a byte offered during WR.
//     -> identical writes. The WR-cycle byte is not consumed until rdy returns.
//  5. PMA_SIZE=4, N=0x0011.
//     -> err=1 the cycle after the second header byte. No PM write. rdy=0.
//  6. Assert reset after 2 data bytes of case 1, then send case 1 again.
//     -> no write from the aborted load. Final PM state and done match case 1.

Source files
------------

// File: rtl/pm_boot_loader.sv
// rtl/pm_boot_loader.sv - boot-time program-memory loader
//
// Purpose: takes a byte stream made of a 2-byte word count N (MSB first),
// N words of PMD_SIZE/8 bytes each (MSB first) and one XOR checksum byte
// covering the data bytes. It writes the assembled words to program memory
// starting at BASE_ADD and keeps the core in reset until the checksum
// matches.
//
// Ports:
//   clk, reset      core clock, synchronous active-high reset
//   ldr_in_vld/dt   input byte stream; a byte transfers when vld & rdy
//   ldr_in_rdy      loader can accept a byte this cycle
//   ldr_pm_cslt     PM chip select / write strobe (one cycle per word)
//   ldr_pm_wrb      PM write enable
//   ldr_pm_add/dt   PM write address / data (hold between writes)
//   ldr_core_rst    core reset, released once the image is verified
//   ldr_done        load complete with a good checksum (sticky)
//   ldr_err         load failed: size overflow or bad checksum (sticky)
module pm_boot_loader #(
  parameter int PMA_SIZE = 16,
  parameter int PMD_SIZE = 32,
  parameter int BASE_ADD = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ldr_in_vld,
  input  logic [7:0]          ldr_in_dt,
  output logic                ldr_in_rdy,
  output logic                ldr_pm_cslt,
  output logic                ldr_pm_wrb,
  output logic [PMA_SIZE-1:0] ldr_pm_add,
  output logic [PMD_SIZE-1:0] ldr_pm_dt,
  output logic                ldr_core_rst,
  output logic                ldr_done,
  output logic                ldr_err
);

  localparam int BPW = PMD_SIZE / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [32:0] PM_DEPTH = 33'd1 << PMA_SIZE;

  typedef enum logic [2:0] {HDR0, HDR1, DATA, WR, CHK, DONE, ERR} state_t;

  state_t              state, state_nx;
  logic                rdy_nx;
  logic [7:0]          n_hi;
  logic [15:0]         n_words;
  // One bit wider than the word count so the index can reach N itself.
  logic [16:0]         widx;
  logic [16:0]         widx_inc;
  logic [BW-1:0]       bcnt;
  logic [7:0]          csum;
  logic [PMD_SIZE-1:0] word;
  logic [PMD_SIZE-1:0] word_nx;
  logic [32:0]         hdr_end;
  logic                take;
  logic                last_byte;

  assign take      = ldr_in_vld & ldr_in_rdy;
  assign widx_inc  = widx + 17'd1;
  assign last_byte = (bcnt == BW'(BPW - 1));
  assign word_nx   = PMD_SIZE'({word, ldr_in_dt});
  // End address of the image, computed wide so an oversized N cannot wrap.
  assign hdr_end   = 33'(BASE_ADD) + {17'd0, n_hi, ldr_in_dt};

  always_ff @(posedge clk) begin
    if (reset) state <= HDR0;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rdy_nx   = 1'b0;
    case (state)
      HDR0: if (take) state_nx = HDR1;
      HDR1: if (take) begin
        if (hdr_end > PM_DEPTH)             state_nx = ERR;
        else if ({n_hi, ldr_in_dt} == 16'd0) state_nx = CHK;
        else                                state_nx = DATA;
      end
      DATA: if (take && last_byte) state_nx = WR;
      WR:   state_nx = (widx_inc == {1'b0, n_words}) ? CHK : DATA;
      CHK:  if (take) state_nx = (ldr_in_dt == csum) ? DONE : ERR;
      DONE: state_nx = DONE;
      ERR:  state_nx = ERR;
      default: state_nx = ERR;
    endcase
    // rdy is registered from the next state, which keeps it low during
    // reset and through the first cycle after reset deasserts.
    rdy_nx = (state_nx == HDR0) || (state_nx == HDR1) ||
             (state_nx == DATA) || (state_nx == CHK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ldr_in_rdy <= 1'b0;
      n_hi       <= '0;
      n_words    <= '0;
      widx       <= '0;
      bcnt       <= '0;
      csum       <= '0;
      word       <= '0;
      ldr_pm_add <= '0;
      ldr_pm_dt  <= '0;
    end else begin
      ldr_in_rdy <= rdy_nx;
      case (state)
        HDR0: if (take) n_hi <= ldr_in_dt;
        HDR1: if (take) n_words <= {n_hi, ldr_in_dt};
        DATA: if (take) begin
          word <= word_nx;
          csum <= csum ^ ldr_in_dt;
          if (last_byte) begin
            // Address and data are loaded here so they are valid during WR.
            bcnt       <= '0;
            ldr_pm_add <= PMA_SIZE'(BASE_ADD) + PMA_SIZE'(widx);
            ldr_pm_dt  <= word_nx;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        WR: widx <= widx_inc;
        default: ;
      endcase
    end
  end

  assign ldr_pm_cslt  = (state == WR);
  assign ldr_pm_wrb   = (state == WR);
  assign ldr_done     = (state == DONE);
  assign ldr_err      = (state == ERR);
  assign ldr_core_rst = (state != DONE);

endmodule

// File: tb/tb_pm_boot_loader.sv
// tb/tb_pm_boot_loader.sv - randomized self-checking bench for pm_boot_loader
module tb_pm_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [2];
  logic       vld  [2];
  logic [7:0] din  [2];
  logic       rdy  [2];
  logic       cslt [2];
  logic       wrb  [2];
  logic       crst [2];
  logic       done [2];
  logic       err  [2];
  logic [15:0] add0;
  logic [31:0] pd0;
  logic [3:0]  add1;
  logic [7:0]  pd1;

  // Instance 0: 32-bit words at base 0. Instance 1: 8-bit words, 16-entry PM, base 2.
  pm_boot_loader #(.PMA_SIZE(16), .PMD_SIZE(32), .BASE_ADD(0)) dut0 (
    .clk(clk), .reset(rst[0]), .ldr_in_vld(vld[0]), .ldr_in_dt(din[0]),
    .ldr_in_rdy(rdy[0]), .ldr_pm_cslt(cslt[0]), .ldr_pm_wrb(wrb[0]),
    .ldr_pm_add(add0), .ldr_pm_dt(pd0), .ldr_core_rst(crst[0]),
    .ldr_done(done[0]), .ldr_err(err[0]));

  pm_boot_loader #(.PMA_SIZE(4), .PMD_SIZE(8), .BASE_ADD(2)) dut1 (
    .clk(clk), .reset(rst[1]), .ldr_in_vld(vld[1]), .ldr_in_dt(din[1]),
    .ldr_in_rdy(rdy[1]), .ldr_pm_cslt(cslt[1]), .ldr_pm_wrb(wrb[1]),
    .ldr_pm_add(add1), .ldr_pm_dt(pd1), .ldr_core_rst(crst[1]),
    .ldr_done(done[1]), .ldr_err(err[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Observed PM writes: {rdy, wrb, addr[31:0], data[31:0]}.
  logic [65:0] wq0[$];
  logic [65:0] wq1[$];
  always @(negedge clk) begin
    if (cslt[0] === 1'b1) wq0.push_back({rdy[0], wrb[0], 32'(add0), pd0});
    if (cslt[1] === 1'b1) wq1.push_back({rdy[1], wrb[1], 28'd0, add1, 24'd0, pd1});
  end

  logic [7:0] stim[$];

  function automatic int cfg_bpw(int sel);  return sel ? 1 : 4;  endfunction
  function automatic int cfg_pma(int sel);  return sel ? 4 : 16; endfunction
  function automatic int cfg_base(int sel); return sel ? 2 : 0;  endfunction

  function automatic logic [31:0] pm_add(int sel);
    return sel ? 32'(add1) : 32'(add0);
  endfunction
  function automatic logic [31:0] pm_dt(int sel);
    return sel ? 32'(pd1) : pd0;
  endfunction
  function automatic int wq_size(int sel);
    return sel ? wq1.size() : wq0.size();
  endfunction

  task automatic reset_dut(input int sel, input string tag);
    rst[sel] = 1'b1;
    vld[sel] = 1'b0;
    repeat (2) @(negedge clk);
    check_eq({tag, "_rst_rdy"},  rdy[sel],  1'b0);
    check_eq({tag, "_rst_crst"}, crst[sel], 1'b1);
    check_eq({tag, "_rst_done"}, done[sel], 1'b0);
    check_eq({tag, "_rst_err"},  err[sel],  1'b0);
    check_eq({tag, "_rst_cslt"}, cslt[sel], 1'b0);
    check_eq({tag, "_rst_add"},  pm_add(sel), 32'd0);
    check_eq({tag, "_rst_dt"},   pm_dt(sel),  32'd0);
    rst[sel] = 1'b0;
    check_eq({tag, "_rdy_low_at_release"}, rdy[sel], 1'b0);
    @(negedge clk);
    check_eq({tag, "_rdy_after_release"}, rdy[sel], 1'b1);
    if (sel == 0) wq0.delete(); else wq1.delete();
  endtask

  // Offers one byte and returns at the negedge following its transfer.
  task automatic push_byte(input int sel, input logic [7:0] b, input int gap);
    int guard;
    while (gap > 0 && $urandom_range(99) < gap) @(negedge clk);
    vld[sel] = 1'b1;
    din[sel] = b;
    guard = 0;
    while (rdy[sel] !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("rdy_within_budget", guard < 50, 1'b1);
    @(negedge clk);
    vld[sel] = 1'b0;
  endtask

  // Sends header N, the bytes in stim and checksum chk, then checks the
  // outcome against the expected image derived from the stream rules.
  task automatic run_load(input int sel, input int n, input logic [7:0] chk,
                          input int gap, input string tag);
    int bpw = cfg_bpw(sel);
    int base = cfg_base(sel);
    bit hdr_err;
    bit exp_done;
    logic [7:0]  x;
    logic [31:0] w;
    logic [65:0] got;
    logic [63:0] expq[$];

    hdr_err = (longint'(base) + longint'(n)) > (longint'(1) << cfg_pma(sel));
    x = 8'h00;
    foreach (stim[k]) x ^= stim[k];
    exp_done = !hdr_err && (chk == x);
    if (!hdr_err)
      for (int i = 0; i < n; i++) begin
        w = 32'd0;
        for (int j = 0; j < bpw; j++) w = (w << 8) | 32'(stim[i * bpw + j]);
        expq.push_back({32'(base + i), w});
      end

    push_byte(sel, 8'(n >> 8), gap);
    push_byte(sel, 8'(n), gap);
    if (!hdr_err) begin
      foreach (stim[k]) push_byte(sel, stim[k], gap);
      push_byte(sel, chk, gap);
    end
    check_eq({tag, "_done"}, done[sel], exp_done);
    check_eq({tag, "_err"},  err[sel],  !exp_done);
    check_eq({tag, "_crst"}, crst[sel], !exp_done);
    check_eq({tag, "_rdy"},  rdy[sel],  1'b0);
    // Further bytes must be ignored and outcome must be sticky.
    vld[sel] = 1'b1;
    din[sel] = 8'h5a;
    repeat (3) @(negedge clk);
    vld[sel] = 1'b0;
    check_eq({tag, "_sticky_done"}, done[sel], exp_done);
    check_eq({tag, "_sticky_rdy"},  rdy[sel],  1'b0);
    check_eq({tag, "_nwrites"}, wq_size(sel), expq.size());
    for (int i = 0; i < expq.size() && i < wq_size(sel); i++) begin
      got = sel ? wq1[i] : wq0[i];
      check_eq($sformatf("%s_w%0d_add", tag, i), got[63:32], expq[i][63:32]);
      check_eq($sformatf("%s_w%0d_dt", tag, i),  got[31:0],  expq[i][31:0]);
      check_eq($sformatf("%s_w%0d_wrb", tag, i), got[64], 1'b1);
      check_eq($sformatf("%s_w%0d_rdy", tag, i), got[65], 1'b0);
    end
  endtask

  task automatic load_case1();
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  endtask

  initial begin
    int sel, n, gap;
    logic [7:0] chk;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; vld[i] = 1'b0; din[i] = 8'h00;
    end
    @(negedge clk);
    reset_dut(1, "init1");

    reset_dut(0, "c1");
    load_case1(); run_load(0, 2, 8'h88, 0, "c1");
    reset_dut(0, "c2");
    load_case1(); run_load(0, 2, 8'h89, 0, "c2");
    reset_dut(0, "c3");
    stim.delete(); run_load(0, 0, 8'h00, 0, "c3");
    reset_dut(0, "c4");
    load_case1(); run_load(0, 2, 8'h88, 50, "c4");

    // Size limit on the 16-entry instance at base 2: 14 words fit, 15 do not.
    stim.delete(); run_load(1, 17, 8'h00, 0, "c5");
    reset_dut(1, "c5b");
    stim.delete();
    for (int i = 0; i < 14; i++) stim.push_back(8'($urandom));
    chk = 8'h00; foreach (stim[k]) chk ^= stim[k];
    run_load(1, 14, chk, 20, "c5_fit");
    reset_dut(1, "c5c");
    stim.delete(); run_load(1, 15, 8'h00, 0, "c5_over");

    // Abort mid-word, then reload.
    reset_dut(0, "c6");
    push_byte(0, 8'h00, 0);
    push_byte(0, 8'h02, 0);
    push_byte(0, 8'h11, 0);
    push_byte(0, 8'h22, 0);
    rst[0] = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("c6_no_abort_write", wq_size(0), 0);
    reset_dut(0, "c6r");
    load_case1(); run_load(0, 2, 8'h88, 30, "c6");

    for (int it = 0; it < 20; it++) begin
      sel = $urandom_range(1);
      n   = sel ? $urandom_range(16) : $urandom_range(4);
      gap = $urandom_range(60);
      reset_dut(sel, $sformatf("r%0d", it));
      stim.delete();
      for (int i = 0; i < n * cfg_bpw(sel); i++) stim.push_back(8'($urandom));
      chk = 8'h00; foreach (stim[k]) chk ^= stim[k];
      if ($urandom_range(3) == 0) chk ^= 8'($urandom_range(255, 1));
      run_load(sel, n, chk, gap, $sformatf("r%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
